// File: rtl/sc_turn_arbiter.sv
// sc_turn_arbiter: grants the shared shift register to one player at a time; optional idle-timeout turn pass via SC_TURN_ARBITER_TIMEOUT_EN
module sc_turn_arbiter #(
  parameter int MOVES_PER_TURN = 1,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int TIMER_W = 26
) (
  input  logic       SC_TURN_ARBITER_CLOCK_50,
  input  logic       SC_TURN_ARBITER_RESET_InHigh,
  input  logic [1:0] SC_TURN_ARBITER_jug1_shiftselection_In,
  input  logic       SC_TURN_ARBITER_jug1_clear_InLow,
  input  logic [1:0] SC_TURN_ARBITER_jug2_shiftselection_In,
  input  logic       SC_TURN_ARBITER_jug2_clear_InLow,
  output logic [1:0] SC_TURN_ARBITER_shiftselection_Out,
  output logic       SC_TURN_ARBITER_clear_OutLow,
  output logic       SC_TURN_ARBITER_jug1_grant_Out,
  output logic       SC_TURN_ARBITER_jug2_grant_Out,
  output logic       SC_TURN_ARBITER_turn_Out,
  output logic       SC_TURN_ARBITER_timeout_Out
);
  localparam int CW = $clog2(MOVES_PER_TURN + 1);
  typedef enum logic [1:0] {IDLE, GRANT1, GRANT2, CLEAR} state_t;
  state_t state, passState;
  logic [CW-1:0] moveCount;
  logic [1:0] shiftReg, cmd;
  logic inGrant, clearReq, moveReq, lastMove;
  if (MOVES_PER_TURN < 1 || TIMER_W < 1 || TIMEOUT_CYCLES < 1) begin : gBadCfg
    $error("sc_turn_arbiter: invalid parameters");
  end
  always_comb begin
    inGrant = state == GRANT1 || state == GRANT2;
    cmd = state == GRANT2 ? SC_TURN_ARBITER_jug2_shiftselection_In : SC_TURN_ARBITER_jug1_shiftselection_In;
    clearReq = !SC_TURN_ARBITER_jug1_clear_InLow || !SC_TURN_ARBITER_jug2_clear_InLow;
    moveReq = inGrant && (cmd[0] ^ cmd[1]);
    lastMove = moveCount == CW'(MOVES_PER_TURN - 1);
    passState = state == GRANT1 ? GRANT2 : GRANT1;
  end
`ifdef SC_TURN_ARBITER_TIMEOUT_EN
  logic [TIMER_W-1:0] timer;
  logic timeoutReg, expired;
  assign expired = inGrant && !clearReq && !moveReq && timer == TIMER_W'(TIMEOUT_CYCLES - 1);
`endif
  always_ff @(posedge SC_TURN_ARBITER_CLOCK_50) begin
    if (SC_TURN_ARBITER_RESET_InHigh) begin
      state <= IDLE;
      moveCount <= '0;
      shiftReg <= 2'b11;
`ifdef SC_TURN_ARBITER_TIMEOUT_EN
      timer <= '0;
      timeoutReg <= 1'b0;
`endif
    end else begin
      shiftReg <= 2'b11;
      if (state == IDLE) state <= GRANT1;
      else if (clearReq) begin
        state <= CLEAR;
        moveCount <= '0;
      end else if (state == CLEAR) begin
        state <= GRANT1;
        moveCount <= '0;
      end else if (moveReq) begin
        shiftReg <= cmd;
        moveCount <= lastMove ? '0 : moveCount + 1'b1;
        if (lastMove) state <= passState;
      end
`ifdef SC_TURN_ARBITER_TIMEOUT_EN
      else if (expired) begin
        state <= passState;
        moveCount <= '0;
      end
      // timer only runs through idle grant cycles; any move, clear or pass restarts it
      timer <= (inGrant && !clearReq && !moveReq && !expired) ? timer + 1'b1 : '0;
      timeoutReg <= expired;
`endif
    end
  end
  assign SC_TURN_ARBITER_shiftselection_Out = shiftReg;
  assign SC_TURN_ARBITER_clear_OutLow = state != CLEAR;
  assign SC_TURN_ARBITER_jug1_grant_Out = state == GRANT1;
  assign SC_TURN_ARBITER_jug2_grant_Out = state == GRANT2;
  assign SC_TURN_ARBITER_turn_Out = state == GRANT2;
`ifdef SC_TURN_ARBITER_TIMEOUT_EN
  assign SC_TURN_ARBITER_timeout_Out = timeoutReg;
`else
  assign SC_TURN_ARBITER_timeout_Out = 1'b0;
`endif
endmodule
